// File: rtl/rs_dep_station.sv
// rs_dep_station
//   Reservation station for one functional unit of the out-of-order core.
//   Each entry holds an op payload and a dependency mask over every RS slot
//   of every FU (GW = RS_ENTRIES*NUM_FUS producers). Completion broadcasts
//   clear dependency bits. An entry requests issue once it is valid and has no
//   outstanding dependencies. An age matrix supplies an oldest-ready pick to
//   the FU arbiter. A grant on a requesting entry issues it and frees it.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           discard every entry (mispredict)
//   disp_valid      dispatch request; disp_dep_mask / disp_payload describe the op
//   complete_mask   producers completing this cycle
//   grant           one-hot issue grant from the arbiter (0 = none)
//   free_entry_out  lowest free entry index (next dispatch target)
//   full_out        all entries valid
//   count_out       number of valid entries
//   reqs            per-entry ready request
//   oldest_sel      one-hot oldest requesting entry (0 if none)
//   issue_valid     grant hit a requesting entry this cycle
//   issue_idx       granted entry index (0 when issue_valid=0)
//   issue_payload   granted entry payload (0 when issue_valid=0)
module rs_dep_station #(
  parameter  int RS_ENTRIES = 4,
  parameter  int NUM_FUS    = 3,
  parameter  int PAYLOAD_W  = 32,
  localparam int GW         = RS_ENTRIES * NUM_FUS,
  localparam int IDX_W      = $clog2(RS_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_valid,
  input  logic [GW-1:0]         disp_dep_mask,
  input  logic [PAYLOAD_W-1:0]  disp_payload,
  input  logic [GW-1:0]         complete_mask,
  input  logic [RS_ENTRIES-1:0] grant,
  output logic [IDX_W-1:0]      free_entry_out,
  output logic                  full_out,
  output logic [IDX_W:0]        count_out,
  output logic [RS_ENTRIES-1:0] reqs,
  output logic [RS_ENTRIES-1:0] oldest_sel,
  output logic                  issue_valid,
  output logic [IDX_W-1:0]      issue_idx,
  output logic [PAYLOAD_W-1:0]  issue_payload
);

  // Entry state. older_q[i][j] = 1 when entry i was dispatched before entry j.
  logic [RS_ENTRIES-1:0] valid_q, valid_d;
  logic [GW-1:0]         dep_q   [RS_ENTRIES];
  logic [GW-1:0]         dep_d   [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  pay_q   [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  pay_d   [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] older_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] older_d [RS_ENTRIES];

  logic [RS_ENTRIES-1:0] grant_hit;
  logic                  disp_acc;
  logic                  issue_fire;

  // Occupancy: free slot, full flag and population count from pre-edge valid bits.
  always_comb begin
    free_entry_out = '0;
    count_out      = '0;
    full_out       = &valid_q;
    // Scan downward so the lowest free index is the last one written.
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_entry_out = IDX_W'(i);
    end
    for (int i = 0; i < RS_ENTRIES; i++) begin
      count_out = count_out + {{IDX_W{1'b0}}, valid_q[i]};
    end
  end

  // Ready requests and oldest-ready selection.
  always_comb begin
    reqs       = '0;
    oldest_sel = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      reqs[i] = valid_q[i] && (dep_q[i] == '0);
    end
    for (int i = 0; i < RS_ENTRIES; i++) begin
      oldest_sel[i] = reqs[i];
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if (j != i && reqs[j] && older_q[j][i]) oldest_sel[i] = 1'b0;
      end
    end
  end

  // Issue: only a grant landing on a requesting entry counts. Should the
  // arbiter ever present more than one bit, the lowest hit wins so that
  // exactly one entry is freed.
  always_comb begin
    grant_hit     = grant & reqs;
    issue_valid   = |grant_hit;
    issue_idx     = '0;
    issue_payload = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (grant_hit[i]) begin
        issue_idx     = IDX_W'(i);
        issue_payload = pay_q[i];
      end
    end
  end

  assign disp_acc   = disp_valid && !full_out && !flush;
  assign issue_fire = issue_valid && !flush;

  // Next-state: wakeup on every entry, then issue and dispatch, flush on top.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      dep_d[i]   = dep_q[i] & ~complete_mask;
      pay_d[i]   = pay_q[i];
      older_d[i] = older_q[i];
    end

    if (issue_fire) begin
      valid_d[issue_idx] = 1'b0;
      older_d[issue_idx] = '0;
      for (int j = 0; j < RS_ENTRIES; j++) begin
        older_d[j][issue_idx] = 1'b0;
      end
    end

    // The dispatch target is always an invalid slot, so it never collides
    // with the issuing entry.
    if (disp_acc) begin
      valid_d[free_entry_out] = 1'b1;
      dep_d[free_entry_out]   = disp_dep_mask & ~complete_mask;
      pay_d[free_entry_out]   = disp_payload;
      older_d[free_entry_out] = '0;
      for (int j = 0; j < RS_ENTRIES; j++) begin
        older_d[j][free_entry_out] = valid_q[j]
                                     && !(issue_fire && (j == int'(issue_idx)))
                                     && (j != int'(free_entry_out));
      end
    end

    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        older_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        dep_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        dep_q[i]   <= dep_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  // Payload is pure data and is only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      pay_q[i] <= pay_d[i];
    end
  end

endmodule

// File: tb/tb_rs_dep_station.sv
module tb_rs_dep_station;

  localparam int RS = 4;
  localparam int GW = 12;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          disp_valid;
  logic [GW-1:0] disp_dep_mask;
  logic [PW-1:0] disp_payload;
  logic [GW-1:0] complete_mask;
  logic [RS-1:0] grant;
  logic [1:0]    free_entry_out;
  logic          full_out;
  logic [2:0]    count_out;
  logic [RS-1:0] reqs;
  logic [RS-1:0] oldest_sel;
  logic          issue_valid;
  logic [1:0]    issue_idx;
  logic [PW-1:0] issue_payload;

  rs_dep_station #(.RS_ENTRIES(RS), .NUM_FUS(3), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_dep_mask(disp_dep_mask), .disp_payload(disp_payload),
    .complete_mask(complete_mask), .grant(grant),
    .free_entry_out(free_entry_out), .full_out(full_out), .count_out(count_out),
    .reqs(reqs), .oldest_sel(oldest_sel),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_payload(issue_payload)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] reqs;
    logic [3:0] old;
    logic [2:0] cnt;
    logic [1:0] fre;
    logic       full;
    logic       iv;
  } snap_t;

  typedef struct {
    int          cyc;
    logic [1:0]  idx;
    logic [31:0] pay;
  } iss_t;

  snap_t sq[$];
  iss_t  iq[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares expected snapshots for this cycle and every issue event.
  snap_t s;
  iss_t  it;
  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      chk({s.name, "_cyc"},    cyc, s.cyc);
      chk({s.name, "_reqs"},   {28'd0, reqs},           {28'd0, s.reqs});
      chk({s.name, "_oldest"}, {28'd0, oldest_sel},     {28'd0, s.old});
      chk({s.name, "_count"},  {29'd0, count_out},      {29'd0, s.cnt});
      chk({s.name, "_free"},   {30'd0, free_entry_out}, {30'd0, s.fre});
      chk({s.name, "_full"},   {31'd0, full_out},       {31'd0, s.full});
      chk({s.name, "_ivalid"}, {31'd0, issue_valid},    {31'd0, s.iv});
      if (!s.iv) chk({s.name, "_idle_issue"}, {30'd0, issue_idx} | issue_payload, 32'd0);
    end
    if (issue_valid === 1'b1) begin
      if (iq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got idx %0d payload %0h expected no issue", issue_idx, issue_payload);
      end else begin
        it = iq.pop_front();
        chk("issue_cyc", cyc, it.cyc);
        chk("issue_idx", {30'd0, issue_idx}, {30'd0, it.idx});
        chk("issue_payload", issue_payload, it.pay);
      end
    end
  end

  task automatic exp_s(string nm, logic [3:0] r, logic [3:0] o, logic [2:0] c,
                       logic [1:0] f, logic fu, logic iv);
    snap_t e;
    e.cyc = cyc; e.name = nm; e.reqs = r; e.old = o;
    e.cnt = c; e.fre = f; e.full = fu; e.iv = iv;
    sq.push_back(e);
  endtask

  task automatic exp_i(logic [1:0] idx, logic [31:0] pay);
    iss_t e;
    e.cyc = cyc; e.idx = idx; e.pay = pay;
    iq.push_back(e);
  endtask

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic drv(logic dv, logic [GW-1:0] dm, logic [PW-1:0] pl,
                     logic [GW-1:0] cm, logic [RS-1:0] gr, logic fl);
    disp_valid = dv; disp_dep_mask = dm; disp_payload = pl;
    complete_mask = cm; grant = gr; flush = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [GW-1:0] B5 = 12'h020;
  localparam logic [GW-1:0] B3 = 12'h008;

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_dep_mask = '0;
    disp_payload = '0; complete_mask = '0; grant = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then single ready dispatch
    exp_s("rst",       4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(0, 0, 0, 0, 0, 0);
    exp_s("t1_pre",    4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(1, 0, 32'h1111_0000, 0, 0, 0);
    exp_s("t1_disp",   4'h1, 4'h1, 3'd1, 2'd1, 1'b0, 1'b1); exp_i(0, 32'h1111_0000);
    drv(0, 0, 0, 0, 4'b0001, 0);

    // Wakeup two cycles after dispatch
    exp_s("t1_empty",  4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(1, B5, 32'h2222_0001, 0, 0, 0);
    exp_s("t2_c1",     4'h0, 4'h0, 3'd1, 2'd1, 1'b0, 1'b0); drv(0, 0, 0, 0, 0, 0);
    exp_s("t2_c2",     4'h0, 4'h0, 3'd1, 2'd1, 1'b0, 1'b0); drv(0, 0, 0, B5, 0, 0);
    exp_s("t2_wake",   4'h1, 4'h1, 3'd1, 2'd1, 1'b0, 1'b1); exp_i(0, 32'h2222_0001);
    drv(0, 0, 0, 0, 4'b0001, 0);

    // Same-cycle wakeup bypass
    exp_s("t3_pre",    4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(1, B5, 32'h3333_0002, B5, 0, 0);
    exp_s("t3_bypass", 4'h1, 4'h1, 3'd1, 2'd1, 1'b0, 1'b1); exp_i(0, 32'h3333_0002);
    drv(0, 0, 0, 0, 4'b0001, 0);

    // Fill, drop when full, grant+dispatch while full, refill freed slot
    exp_s("t4_e0",     4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(1, 0, 32'hF000_0000, 0, 0, 0);
    exp_s("t4_e1",     4'h1, 4'h1, 3'd1, 2'd1, 1'b0, 1'b0); drv(1, 0, 32'hF000_0001, 0, 0, 0);
    exp_s("t4_e2",     4'h3, 4'h1, 3'd2, 2'd2, 1'b0, 1'b0); drv(1, 0, 32'hF000_0002, 0, 0, 0);
    exp_s("t4_e3",     4'h7, 4'h1, 3'd3, 2'd3, 1'b0, 1'b0); drv(1, 0, 32'hF000_0003, 0, 0, 0);
    exp_s("t4_full",   4'hF, 4'h1, 3'd4, 2'd0, 1'b1, 1'b0); drv(1, 0, 32'hDEAD_BEEF, 0, 0, 0);
    exp_s("t4_drop",   4'hF, 4'h1, 3'd4, 2'd0, 1'b1, 1'b1); exp_i(1, 32'hF000_0001);
    drv(1, 0, 32'hDEAD_BEEF, 0, 4'b0010, 0);
    exp_s("t4_freed",  4'hD, 4'h1, 3'd3, 2'd1, 1'b0, 1'b0); drv(1, 0, 32'hF000_0004, 0, 0, 0);
    exp_s("t4_refill", 4'hF, 4'h1, 3'd4, 2'd0, 1'b1, 1'b1); exp_i(1, 32'hF000_0004);
    drv(0, 0, 0, 0, 4'b0010, 0);

    // Flush with dispatch and grant; then grant to an empty entry
    exp_s("t6_pre",    4'hD, 4'h1, 3'd3, 2'd1, 1'b0, 1'b1); exp_i(0, 32'hF000_0000);
    drv(1, 0, 32'hDEAD_BEEF, 0, 4'b0001, 1);
    exp_s("t6_flushed",4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(0, 0, 0, 0, 4'b0100, 0);

    // Oldest pick follows age, not readiness order
    exp_s("t5_pre",    4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(1, B3, 32'hAAAA_000A, 0, 0, 0);
    exp_s("t5_a",      4'h0, 4'h0, 3'd1, 2'd1, 1'b0, 1'b0); drv(1, 0, 32'hBBBB_000B, 0, 0, 0);
    exp_s("t5_b",      4'h2, 4'h2, 3'd2, 2'd2, 1'b0, 1'b0); drv(1, 0, 32'hCCCC_000C, 0, 0, 0);
    exp_s("t5_c",      4'h6, 4'h2, 3'd3, 2'd3, 1'b0, 1'b0); drv(0, 0, 0, B3, 0, 0);
    exp_s("t5_wake",   4'h7, 4'h1, 3'd3, 2'd3, 1'b0, 1'b1); exp_i(0, 32'hAAAA_000A);
    drv(0, 0, 0, 0, 4'b0001, 0);
    exp_s("t5_post_a", 4'h6, 4'h2, 3'd2, 2'd0, 1'b0, 1'b1); exp_i(2, 32'hCCCC_000C);
    drv(0, 0, 0, 0, 4'b0100, 0);
    exp_s("t5_post_c", 4'h2, 4'h2, 3'd1, 2'd0, 1'b0, 1'b0); drv(0, 0, 0, 0, 4'b0001, 0);
    exp_s("t5_bad_gnt",4'h2, 4'h2, 3'd1, 2'd0, 1'b0, 1'b1); exp_i(1, 32'hBBBB_000B);
    drv(0, 0, 0, 0, 4'b0010, 0);
    exp_s("t5_done",   4'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0); drv(0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    chk("snap_queue_drained",  sq.size(), 0);
    chk("issue_queue_drained", iq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
